rrg_cmd_master: RTL

- Host-side initiator for the ramp generator's multiplexed command interface.
- Converts single-transaction host requests into the timed reg_control / reg_0..reg_3 command sequences that the ramp generator consumes.
- Captures outreg_0..outreg_3 readback data and returns it on a response port.
- Sits between the bus slave (Wishbone/SCU glue) and the ramp generator instance, in the same fast clock domain.

---
 rtl/rrg_cmd_master.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rrg_cmd_master.sv
// Host-side command master for the ramp generator: turns one host request into the
// timed reg_control / reg_0..reg_3 step sequence and returns outreg readback on a response.
module rrg_cmd_master #(
  parameter int HOLD_CYCLES  = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_dataset,
  input  logic [7:0]  cmd_rd_code,
  input  logic [63:0] cmd_y,
  input  logic [63:0] cmd_r,
  input  logic [63:0] cmd_ri,
  input  logic [63:0] cmd_ro,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [63:0] rsp_data,
  output logic [15:0] reg_control,
  output logic [15:0] reg_0,
  output logic [15:0] reg_1,
  output logic [15:0] reg_2,
  output logic [15:0] reg_3,
  input  logic [15:0] outreg_0,
  input  logic [15:0] outreg_1,
  input  logic [15:0] outreg_2,
  input  logic [15:0] outreg_3
);

  // Handshake: a request is taken on a clk edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE (and never during reset). Responses have no backpressure.
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ASSERT, S_RELEASE, S_WAIT_RD, S_RESP
  } state_t;

  localparam logic [2:0] OP_WRITE_SET = 3'd0;
  localparam logic [2:0] OP_SW_DS     = 3'd1;
  localparam logic [2:0] OP_EXT_DS    = 3'd2;
  localparam logic [2:0] OP_NUM_CYCLE = 3'd3;
  localparam logic [2:0] OP_HALT      = 3'd4;
  localparam logic [2:0] OP_READ      = 3'd5;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  ds_q, ds_d;
  logic [7:0]  rdc_q, rdc_d;
  logic [63:0] y_q, y_d, r_q, r_d, ri_q, ri_d, ro_q, ro_d;
  logic [63:0] rd_q, rd_d;

  logic        last_step;
  logic [7:0]  step_code;
  logic [63:0] step_data;
  logic        busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      ds_q    <= '0;
      rdc_q   <= '0;
      y_q     <= '0;
      r_q     <= '0;
      ri_q    <= '0;
      ro_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ds_q    <= ds_d;
      rdc_q   <= rdc_d;
      y_q     <= y_d;
      r_q     <= r_d;
      ri_q    <= ri_d;
      ro_q    <= ro_d;
      rd_q    <= rd_d;
    end
  end

  // WRITE_SET walks five steps; every other legal op is a single step.
  assign last_step = (op_q == OP_WRITE_SET) ? (step_q == 3'd4) : 1'b1;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ds_d    = ds_q;
    rdc_d   = rdc_q;
    y_d     = y_q;
    r_d     = r_q;
    ri_d    = ri_q;
    ro_d    = ro_q;
    rd_d    = rd_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          ds_d    = cmd_dataset;
          rdc_d   = cmd_rd_code;
          y_d     = cmd_y;
          r_d     = cmd_r;
          ri_d    = cmd_ri;
          ro_d    = cmd_ro;
          rd_d    = '0;
          step_d  = '0;
          cnt_d   = '0;
          state_d = (cmd_op > OP_READ) ? S_RESP : S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ASSERT;
      end
      S_ASSERT: begin
        if (cnt_q == 8'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (op_q == OP_READ) ? S_WAIT_RD : S_RELEASE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RELEASE: begin
        if (last_step) begin
          state_d = S_RESP;
        end else begin
          step_d  = step_q + 3'd1;
          state_d = S_SETUP;
        end
      end
      S_WAIT_RD: begin
        if (cnt_q == 8'(READ_LATENCY - 1)) begin
          rd_d    = {outreg_3, outreg_2, outreg_1, outreg_0};
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    step_code = 8'd0;
    step_data = 64'd0;
    case (op_q)
      OP_WRITE_SET: begin
        step_code = 8'd1 + {5'd0, step_q};
        case (step_q)
          3'd0:    step_data = y_q;
          3'd1:    step_data = r_q;
          3'd2:    step_data = ri_q;
          default: step_data = ro_q;
        endcase
      end
      OP_SW_DS:     step_code = 8'd6;
      OP_EXT_DS:    step_code = 8'd7;
      OP_NUM_CYCLE: begin
        step_code = 8'd8;
        step_data = {32'd0, y_q[31:0]};
      end
      OP_HALT:      step_code = 8'd9;
      OP_READ:      step_code = rdc_q;
      default:      step_code = 8'd0;
    endcase

    busy = (state_q == S_SETUP) || (state_q == S_ASSERT) ||
           (state_q == S_RELEASE) || (state_q == S_WAIT_RD);

    // The command byte is non-zero only in ASSERT, so data moves only while it is 0.
    reg_control = busy ? {ds_q, (state_q == S_ASSERT) ? step_code : 8'd0} : 16'd0;
    {reg_3, reg_2, reg_1, reg_0} = busy ? step_data : 64'd0;

    cmd_ready = (state_q == S_IDLE) && !reset;
    rsp_valid = (state_q == S_RESP);
    rsp_err   = (state_q == S_RESP) && (op_q > OP_READ);
    rsp_data  = (state_q == S_RESP) ? rd_q : 64'd0;
  end

endmodule
